// File: rtl/mult_rr_scheduler.sv
// Round-robin front end that time-shares one combinational multiplier among NUM_REQ clients.
// Optional MULT_SCHED_B2B_EN: grant the next request during the response handshake cycle.
module mult_rr_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned OP_W    = 8,
    parameter int unsigned RES_W   = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic [OP_W-1:0]         mul_a,
    output logic [OP_W-1:0]         mul_b,
    input  logic [RES_W-1:0]        mul_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [RES_W-1:0]        rsp_data,
    output logic                    busy
);

`ifdef MULT_SCHED_B2B_EN
    localparam bit B2bEn = 1'b1;
`else
    localparam bit B2bEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StIssue, StRespond} state_e;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   mul_a_q, mul_a_d;
    logic [OP_W-1:0]   mul_b_q, mul_b_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [RES_W-1:0]  rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   search_idx;
    logic              accept;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        search_idx  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            search_idx = ID_W'((32'(last_grant_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[search_idx]) begin
                grant_found = 1'b1;
                grant_id    = search_idx;
            end
        end
    end

    always_comb begin
        accept = 1'b0;
        if (grant_found) begin
            if (state_q == StIdle) begin
                accept = 1'b1;
            end else if (B2bEn && (state_q == StRespond) && rsp_ready) begin
                accept = 1'b1;
            end
        end
    end

    assign req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;

    always_comb begin
        state_d      = state_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = rsp_valid_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                rsp_data_d  = mul_result;
                rsp_valid_d = 1'b1;
                state_d     = StRespond;
            end
            StRespond: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = accept ? StIssue : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Operands are sampled only on the accepting cycle.
        if (accept) begin
            mul_a_d      = req_a[32'(grant_id) * OP_W +: OP_W];
            mul_b_d      = req_b[32'(grant_id) * OP_W +: OP_W];
            rsp_id_d     = grant_id;
            last_grant_d = grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp_id_q     <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            rsp_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler with a scoreboard-driven response monitor.
// Multiplier is a stub returning the zero-extended unsigned product.
module tb_mult_rr_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned OP_W    = 8;
    localparam int unsigned RES_W   = 17;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [RES_W-1:0] data;
    } rsp_t;

    logic                    clk;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*OP_W-1:0] req_a;
    logic [NUM_REQ*OP_W-1:0] req_b;
    logic [OP_W-1:0]         mul_a;
    logic [OP_W-1:0]         mul_b;
    logic [RES_W-1:0]        mul_result;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [RES_W-1:0]        rsp_data;
    logic                    busy;

    rsp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    mult_rr_scheduler #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W),
        .OP_W   (OP_W),
        .RES_W  (RES_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_result(mul_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    assign mul_result = RES_W'(mul_a) * RES_W'(mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_rsp(input int unsigned id, input int unsigned data);
        rsp_t e;
        e.id   = ID_W'(id);
        e.data = RES_W'(data);
        exp_q.push_back(e);
    endtask

    task automatic set_op(input int unsigned i, input int unsigned a, input int unsigned b);
        req_a[i*OP_W +: OP_W] = OP_W'(a);
        req_b[i*OP_W +: OP_W] = OP_W'(b);
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        next();
        next();
        rst = 1'b0;
    endtask

    // Inputs change only at negedge, so a handshake seen here completes at the next posedge.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got id %0d data %0d, required no response",
                             rsp_id, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish by 200000");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        next();
        next();
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_mul_a", 32'(mul_a), 0);
        check("reset_mul_b", 32'(mul_b), 0);
        check("reset_rsp_id", 32'(rsp_id), 0);
        check("reset_rsp_data", 32'(rsp_data), 0);
        check("reset_req_ready", 32'(req_ready), 0);

        // Single operation
        next();
        rst       = 1'b0;
        req_valid = 4'b0001;
        set_op(0, 5, 3);
        rsp_ready = 1'b1;
        #1;
        check("single_grant", 32'(req_ready), 32'h1);
        check("single_idle_busy", 32'(busy), 0);
        expect_rsp(0, 15);
        next();
        req_valid = '0;
        #1;
        check("single_issue_ready", 32'(req_ready), 0);
        check("single_issue_busy", 32'(busy), 1);
        check("single_issue_valid", 32'(rsp_valid), 0);
        check("single_mul_a", 32'(mul_a), 5);
        check("single_mul_b", 32'(mul_b), 3);
        next();
        #1;
        check("single_rsp_valid", 32'(rsp_valid), 1);
        check("single_rsp_busy", 32'(busy), 1);
        next();
        #1;
        check("single_done_valid", 32'(rsp_valid), 0);
        check("single_done_busy", 32'(busy), 0);
        check("single_mul_a_held", 32'(mul_a), 5);

        // Round-robin with all requesters valid
        do_reset();
        req_valid = 4'b1111;
        for (int unsigned i = 0; i < NUM_REQ; i++) set_op(i, i + 1, 2);
        for (int unsigned i = 0; i < 5; i++) begin
            #1;
            check("rr_grant", 32'(req_ready), 32'(1) << (i % NUM_REQ));
            expect_rsp(i % NUM_REQ, 2 * ((i % NUM_REQ) + 1));
            next();
            #1;
            check("rr_issue_ready", 32'(req_ready), 0);
            next();
            next();
        end
        req_valid = '0;
        next();
        next();

        // Backpressure: last grant was 0, so requester 1 is next
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        set_op(1, 7, 9);
        #1;
        check("bp_grant", 32'(req_ready), 32'h2);
        expect_rsp(1, 63);
        next();
        req_valid = '0;
        next();
        #1;
        check("bp_first_valid", 32'(rsp_valid), 1);
        for (int j = 0; j < 5; j++) begin
            next();
            req_valid = 4'b0001;
            #1;
            check("bp_hold_valid", 32'(rsp_valid), 1);
            check("bp_hold_id", 32'(rsp_id), 1);
            check("bp_hold_data", 32'(rsp_data), 63);
            check("bp_hold_ready", 32'(req_ready), 0);
        end
        next();
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        check("bp_release_valid", 32'(rsp_valid), 1);
        next();
        #1;
        check("bp_after_valid", 32'(rsp_valid), 0);
        check("bp_after_busy", 32'(busy), 0);

        // Skip and withdraw: last grant 1
        req_valid = 4'b0100;
        set_op(2, 3, 4);
        #1;
        check("skip_grant2", 32'(req_ready), 32'h4);
        expect_rsp(2, 12);
        next();
        req_valid = 4'b1010;
        set_op(1, 6, 5);
        set_op(3, 9, 9);
        #1;
        check("skip_issue_ready", 32'(req_ready), 0);
        next();
        req_valid = 4'b0010;
        #1;
        check("skip_respond_ready", 32'(req_ready), 0);
        next();
        #1;
        check("skip_grant1", 32'(req_ready), 32'h2);
        expect_rsp(1, 30);
        next();
        req_valid = '0;
        next();
        next();
        #1;
        check("skip_done_busy", 32'(busy), 0);

        // Reset during ISSUE: last grant 1, so requester 2 is granted first
        next();
        req_valid = 4'b0100;
        set_op(2, 3, 4);
        #1;
        check("rst_pre_grant", 32'(req_ready), 32'h4);
        next();
        rst       = 1'b1;
        req_valid = '0;
        #1;
        check("rst_issue_mul_a", 32'(mul_a), 3);
        check("rst_issue_busy", 32'(busy), 1);
        next();
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mul_a", 32'(mul_a), 0);
        check("rst_mul_b", 32'(mul_b), 0);
        rst       = 1'b0;
        req_valid = 4'b1111;
        for (int unsigned i = 0; i < NUM_REQ; i++) set_op(i, i + 1, 2);
        #1;
        check("rst_first_grant", 32'(req_ready), 32'h1);
        expect_rsp(0, 2);
        next();
        req_valid = '0;
        next();
        next();
        #1;
        check("rst_done_busy", 32'(busy), 0);

`ifdef MULT_SCHED_B2B_EN
        // Back-to-back: last grant 0, requesters 0 and 1 alternate every 2 cycles
        next();
        req_valid = 4'b0011;
        set_op(0, 5, 3);
        set_op(1, 7, 9);
        #1;
        check("b2b_grant1", 32'(req_ready), 32'h2);
        expect_rsp(1, 63);
        next();
        #1;
        check("b2b_issue_ready", 32'(req_ready), 0);
        next();
        #1;
        check("b2b_rsp1_valid", 32'(rsp_valid), 1);
        check("b2b_grant0", 32'(req_ready), 32'h1);
        expect_rsp(0, 15);
        next();
        #1;
        check("b2b_issue2_valid", 32'(rsp_valid), 0);
        check("b2b_issue2_busy", 32'(busy), 1);
        next();
        #1;
        check("b2b_rsp2_valid", 32'(rsp_valid), 1);
        check("b2b_grant1_again", 32'(req_ready), 32'h2);
        expect_rsp(1, 63);
        next();
        req_valid = '0;
        next();
        #1;
        check("b2b_rsp3_valid", 32'(rsp_valid), 1);
        check("b2b_rsp3_ready", 32'(req_ready), 0);
        next();
        #1;
        check("b2b_done_busy", 32'(busy), 0);
`endif

        repeat (3) next();
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
